// File: rtl/foreground_frame_controller_if.sv
// foreground_frame_controller_if: frame RAM read bus, mask sink handshake and background write bus
//   master (controller): drives rd_en/rd_addr, mask_valid/mask_addr/mask_bit, bg_wr_en/bg_wr_addr/bg_wr_rgb;
//                        receives cur_rgb/bg_rgb (one cycle after rd_en) and mask_ready
//   slave (RAMs/sink):   the opposite directions
interface foreground_frame_controller_if #(
    parameter int ADDR_W = 12
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [23:0]       cur_rgb;
    logic [23:0]       bg_rgb;
    logic              mask_valid;
    logic              mask_ready;
    logic [ADDR_W-1:0] mask_addr;
    logic              mask_bit;
    logic              bg_wr_en;
    logic [ADDR_W-1:0] bg_wr_addr;
    logic [23:0]       bg_wr_rgb;
    modport master (
        output rd_en, rd_addr, mask_valid, mask_addr, mask_bit, bg_wr_en, bg_wr_addr, bg_wr_rgb,
        input  cur_rgb, bg_rgb, mask_ready
    );
    modport slave (
        input  rd_en, rd_addr, mask_valid, mask_addr, mask_bit, bg_wr_en, bg_wr_addr, bg_wr_rgb,
        output cur_rgb, bg_rgb, mask_ready
    );
endinterface

// File: rtl/foreground_frame_controller.sv
// foreground_frame_controller: walks every pixel once per frame, feeds the detector, emits mask bits and updates the background
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, learn          : frame start pulse (IDLE only) and learn-mode select sampled with it
//   busy, done            : frame in progress, one-cycle completion pulse
//   det_current_rgb,
//   det_background_rgb    : registered pixel pair to the combinational detector
//   det_is_foreground     : detector result
//   bus                   : frame RAM reads, mask sink handshake, background RAM writes
module foreground_frame_controller #(
    parameter int NUM_PIXELS   = 3072,
    parameter int ADDR_W       = 12,
    parameter int UPDATE_SHIFT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        learn,
    output logic        busy,
    output logic        done,
    output logic [23:0] det_current_rgb,
    output logic [23:0] det_background_rgb,
    input  logic        det_is_foreground,
    foreground_frame_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EVAL,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              learn_q, learn_d;
    logic [23:0]       cur_q, cur_d;
    logic [23:0]       bkg_q, bkg_d;
    logic              mask_bit_q, mask_bit_d;
    logic [23:0]       wr_rgb_q, wr_rgb_d;
    logic              hs;
    logic              last;

    // Running-average step on one channel: bg + floor((cur - bg) / 2^UPDATE_SHIFT), clamped to 0..255.
    function automatic logic [7:0] blend(input logic [7:0] c, input logic [7:0] b);
        logic signed [8:0] d;
        logic signed [8:0] sh;
        logic signed [9:0] s;
        d  = $signed({1'b0, c}) - $signed({1'b0, b});
        sh = d >>> UPDATE_SHIFT;
        s  = $signed({2'b00, b}) + $signed({sh[8], sh});
        return s < 10'sd0 ? 8'd0 : s > 10'sd255 ? 8'd255 : s[7:0];
    endfunction

    assign hs   = (state_q == S_WRITE) && bus.mask_ready;
    assign last = cnt_q == LAST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            learn_q    <= 1'b0;
            cur_q      <= '0;
            bkg_q      <= '0;
            mask_bit_q <= 1'b0;
            wr_rgb_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            learn_q    <= learn_d;
            cur_q      <= cur_d;
            bkg_q      <= bkg_d;
            mask_bit_q <= mask_bit_d;
            wr_rgb_q   <= wr_rgb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_READ : S_IDLE;
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_EVAL;
            S_EVAL:  state_d = S_WRITE;
            S_WRITE: state_d = !hs ? S_WRITE : last ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: everything except the counter is held through a WRITE stall.
    always_comb begin
        cnt_d      = (state_q == S_IDLE && start) ? '0 : (hs && !last) ? cnt_q + 1'b1 : cnt_q;
        learn_d    = (state_q == S_IDLE && start) ? learn : learn_q;
        cur_d      = (state_q == S_WAIT) ? bus.cur_rgb : cur_q;
        bkg_d      = (state_q == S_WAIT) ? bus.bg_rgb : bkg_q;
        mask_bit_d = (state_q == S_EVAL) ? det_is_foreground : mask_bit_q;
        wr_rgb_d   = (state_q != S_EVAL) ? wr_rgb_q :
                     learn_q ? cur_q :
                     {blend(cur_q[23:16], bkg_q[23:16]), blend(cur_q[15:8], bkg_q[15:8]), blend(cur_q[7:0], bkg_q[7:0])};
    end

    always_comb begin
        busy               = state_q inside {S_READ, S_WAIT, S_EVAL, S_WRITE};
        done               = state_q == S_DONE;
        bus.rd_en          = state_q == S_READ;
        bus.rd_addr        = cnt_q;
        bus.mask_valid     = state_q == S_WRITE;
        bus.mask_addr      = cnt_q;
        bus.mask_bit       = mask_bit_q;
        // Foreground pixels leave the background untouched unless the frame is being learned.
        bus.bg_wr_en       = hs && (learn_q || !mask_bit_q);
        bus.bg_wr_addr     = cnt_q;
        bus.bg_wr_rgb      = wr_rgb_q;
        det_current_rgb    = cur_q;
        det_background_rgb = bkg_q;
    end
endmodule

// File: tb/tb_foreground_frame_controller.sv
// tb_foreground_frame_controller: directed frames against a 4-pixel controller with RAM and detector models
module tb_foreground_frame_controller;
    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        learn;
    logic        busy;
    logic        done;
    logic [23:0] det_cur;
    logic [23:0] det_bg;
    logic        det_fg;

    foreground_frame_controller_if #(.ADDR_W(12)) bus ();

    foreground_frame_controller #(.NUM_PIXELS(NP), .ADDR_W(12), .UPDATE_SHIFT(3)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .learn(learn),
        .busy(busy),
        .done(done),
        .det_current_rgb(det_cur),
        .det_background_rgb(det_bg),
        .det_is_foreground(det_fg),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [23:0] cur_mem [NP];
    logic [23:0] bg_mem  [NP];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.cur_rgb <= cur_mem[bus.rd_addr[1:0]];
            bus.bg_rgb  <= bg_mem[bus.rd_addr[1:0]];
        end
    end

    function automatic logic far(input logic [7:0] a, input logic [7:0] b);
        return (a > b ? a - b : b - a) > 8'd25;
    endfunction

    assign det_fg = far(det_cur[23:16], det_bg[23:16]) || far(det_cur[15:8], det_bg[15:8]) || far(det_cur[7:0], det_bg[7:0]);

    int          rd_n = 0, mk_n = 0, wr_n = 0, done_n = 0;
    logic [11:0] rd_a [64];
    logic [11:0] mk_a [64];
    logic        mk_b [64];
    logic [11:0] wr_a [64];
    logic [23:0] wr_d [64];

    always @(negedge clk) begin
        if (bus.rd_en && rd_n < 64) begin
            rd_a[rd_n] = bus.rd_addr;
            rd_n++;
        end
        if (bus.mask_valid && bus.mask_ready && mk_n < 64) begin
            mk_a[mk_n] = bus.mask_addr;
            mk_b[mk_n] = bus.mask_bit;
            mk_n++;
        end
        if (bus.bg_wr_en && wr_n < 64) begin
            wr_a[wr_n] = bus.bg_wr_addr;
            wr_d[wr_n] = bus.bg_wr_rgb;
            wr_n++;
        end
        if (done) done_n++;
    end

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {busy, done, bus.rd_en, bus.mask_valid, bus.bg_wr_en, bus.mask_bit}, 0);
        check({tag, "_addr"}, {bus.rd_addr, bus.mask_addr, bus.bg_wr_addr}, 0);
        check({tag, "_det"}, {det_cur, det_bg}, 0);
        check({tag, "_wrd"}, bus.bg_wr_rgb, 0);
    endtask

    task automatic run_frame(input logic lrn, input logic [3:0] exp_m, input logic [3:0] exp_we, input logic [95:0] exp_w);
        int rb, mb, wb, db, cyc, j, nw;
        rb = rd_n; mb = mk_n; wb = wr_n; db = done_n;
        @(negedge clk);
        start = 1'b1;
        learn = lrn;
        @(posedge clk);
        #1;
        start = 1'b0;
        learn = 1'b0;
        cyc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_on", busy, 1);
            if (done) break;
        end
        check("done_lat", cyc, 17);
        check("done_busy", busy, 0);
        @(negedge clk);
        check("done_len", done, 0);
        check("rd_cnt", rd_n - rb, NP);
        check("mk_cnt", mk_n - mb, NP);
        for (int i = 0; i < NP; i++) begin
            check("rd_addr", rd_a[rb + i], i);
            check("mk_addr", mk_a[mb + i], i);
            check("mk_bit", mk_b[mb + i], exp_m[i]);
        end
        nw = 0;
        for (int i = 0; i < NP; i++) nw += int'(exp_we[i]);
        check("wr_cnt", wr_n - wb, nw);
        j = 0;
        for (int i = 0; i < NP; i++) begin
            if (exp_we[i] && j < wr_n - wb) begin
                check("wr_addr", wr_a[wb + j], i);
                check("wr_data", wr_d[wb + j], exp_w[i*24 +: 24]);
                j++;
            end
        end
        check("done_cnt", done_n - db, 1);
    endtask

    initial begin
        int rb, db, cyc;
        cur_mem[0] = 24'h646464; bg_mem[0] = 24'h5A5A5A;
        cur_mem[1] = 24'h50C85A; bg_mem[1] = 24'h5ABE5A;
        cur_mem[2] = 24'hC80A0A; bg_mem[2] = 24'h0A0A0A;
        cur_mem[3] = 24'h323C46; bg_mem[3] = 24'h284646;
        reset_n = 1'b0;
        start = 1'b0;
        learn = 1'b0;
        bus.mask_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("idle");

        run_frame(1'b0, 4'b0100, 4'b1011, {24'h294446, 24'h000000, 24'h58BF5A, 24'h5B5B5B});
        run_frame(1'b1, 4'b0100, 4'b1111, {24'h323C46, 24'hC80A0A, 24'h50C85A, 24'h646464});

        bus.mask_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (cyc = 0; cyc < 50 && !bus.mask_valid; cyc++) @(negedge clk);
        check("bp_valid0", bus.mask_valid, 1);
        #1;
        bus.mask_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.mask_ready = 1'b0;
        for (cyc = 0; cyc < 50 && !bus.mask_valid; cyc++) @(negedge clk);
        check("bp_valid1", bus.mask_valid, 1);
        check("bp_addr1", bus.mask_addr, 1);
        rb = rd_n;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {bus.mask_valid, bus.mask_addr, bus.mask_bit, bus.bg_wr_en, bus.bg_wr_rgb}, {1'b1, 12'd1, 1'b0, 1'b0, 24'h58BF5A});
        end
        check("bp_no_rd", rd_n - rb, 0);
        db = done_n;
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("mid_rst");
        repeat (3) @(negedge clk);
        check("rst_no_done", done_n - db, 0);
        reset_n = 1'b1;
        bus.mask_ready = 1'b1;
        run_frame(1'b0, 4'b0100, 4'b1011, {24'h294446, 24'h000000, 24'h58BF5A, 24'h5B5B5B});

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
